// File: rtl/sram_arbiter.sv
// Two-port arbiter sharing one 16-bit SRAM between instruction fetch and data memory.
// Each 32-bit word request becomes two sequential half-word accesses (low half, then high half).
// Arbitration is round-robin on contention and happens only while idle.
module sram_arbiter #(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [16:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [16:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        SRAMWEn,
  output logic [17:0] SRAMaddress,
  inout  wire  [15:0] SRAMdata,
  output logic        busy
);

  localparam int unsigned CntW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CntW-1:0] WaitLast = CntW'(WAIT_STATES);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StAck} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_q, wait_d;
  logic            grant_dm_q, grant_dm_d;  // owner of the current transaction
  logic            last_dm_q, last_dm_d;    // owner of the most recent grant
  logic            we_q, we_d;
  logic [16:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [15:0]     rlo_q, rlo_d;            // low half captured while the high half is fetched
  logic [31:0]     if_rdata_q, if_rdata_d;
  logic [31:0]     dm_rdata_q, dm_rdata_d;
  logic [17:0]     sram_addr_q, sram_addr_d;

  logic phase_done;
  logic in_phase;
  logic drive_bus;

  assign phase_done = (wait_q == WaitLast);
  assign in_phase   = (state_q == StLo) || (state_q == StHi);
  assign drive_bus  = in_phase && we_q;

  // Next-state, grant and capture logic
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    grant_dm_d  = grant_dm_q;
    last_dm_d   = last_dm_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rlo_d       = rlo_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    sram_addr_d = sram_addr_q;

    unique case (state_q)
      StIdle: begin
        if (dm_req || if_req) begin
          // On contention the port that did not win last time gets the bus
          grant_dm_d  = dm_req && (!if_req || !last_dm_q);
          last_dm_d   = grant_dm_d;
          we_d        = grant_dm_d ? dm_we : 1'b0;
          addr_d      = grant_dm_d ? dm_addr : if_addr;
          wdata_d     = dm_wdata;
          sram_addr_d = {addr_d, 1'b0};
          wait_d      = '0;
          state_d     = StLo;
        end
      end
      StLo: begin
        if (phase_done) begin
          if (!we_q) rlo_d = SRAMdata;
          sram_addr_d = {addr_q, 1'b1};
          wait_d      = '0;
          state_d     = StHi;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StHi: begin
        if (phase_done) begin
          if (!we_q) begin
            if (grant_dm_q) dm_rdata_d = {SRAMdata, rlo_q};
            else            if_rdata_d = {SRAMdata, rlo_q};
          end
          wait_d  = '0;
          state_d = StAck;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wait_q      <= '0;
      grant_dm_q  <= 1'b0;
      last_dm_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rlo_q       <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      sram_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      grant_dm_q  <= grant_dm_d;
      last_dm_q   <= last_dm_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rlo_q       <= rlo_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      sram_addr_q <= sram_addr_d;
    end
  end

  // Pin and handshake outputs decoded from registered state
  always_comb begin
    SRAMWEn     = ~drive_bus;
    SRAMaddress = sram_addr_q;
    if_ack      = (state_q == StAck) && !grant_dm_q;
    dm_ack      = (state_q == StAck) && grant_dm_q;
    if_rdata    = if_rdata_q;
    dm_rdata    = dm_rdata_q;
    busy        = (state_q != StIdle);
  end

  assign SRAMdata = drive_bus ? ((state_q == StHi) ? wdata_q[31:16] : wdata_q[15:0]) : 16'hzzzz;

endmodule
